sdram_fb_arbiter: RTL and testbench

// Parametrised successor of the camera-to-VGA SDRAM frame-buffer controller. Arbitrates word-wide bursts

---
 rtl/sdram_fb_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_sdram_fb_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_fb_arbiter.sv
// SDRAM frame-buffer arbiter: camera write FIFO vs display read FIFO over single-beat Avalon-MM.
// Optional FB_STATS_EN adds saturating write-frame and read-repeat statistics outputs.
module sdram_fb_arbiter #(
    parameter int DW           = 16,
    parameter int AW           = 24,
    parameter int LVL_W        = 11,
    parameter int BL           = 256,
    parameter int FRAME_BURSTS = 3072,
    parameter int NBUF         = 2,
    parameter int RD_LT        = 256,
    parameter int RD_UT        = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [LVL_W-1:0] wf_usedw,
    input  logic [DW-1:0]    wf_data,
    output logic             wf_rdreq,
    output logic             wr_allow,
    input  logic [LVL_W-1:0] rf_usedw,
    output logic             rf_wrreq,
    output logic [DW-1:0]    rf_data,
    output logic             avm_write,
    output logic             avm_read,
    output logic [AW-1:0]    avm_addr,
    output logic [DW-1:0]    avm_wrdata,
    input  logic [DW-1:0]    avs_rddata,
    input  logic             avs_rddata_vld,
    input  logic             avs_waitrequest
`ifdef FB_STATS_EN
    ,
    output logic [15:0]      stat_wr_frames,
    output logic [15:0]      stat_rd_repeats
`endif
);

    localparam int WW   = AW - 2;
    localparam int BC_W = (BL > 1) ? $clog2(BL) : 1;
    localparam int PW   = BC_W + 3;

    localparam logic [LVL_W-1:0] BL_LVL    = LVL_W'(BL);
    localparam logic [LVL_W-1:0] RD_LT_LVL = LVL_W'(RD_LT);
    localparam logic [LVL_W-1:0] RD_UT_LVL = LVL_W'(RD_UT);
    localparam logic [BC_W-1:0]  LAST_BEAT = BC_W'(BL - 1);
    localparam logic [WW-1:0]    LAST_WORD = WW'(FRAME_BURSTS * BL - 1);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    state_t          state;
    state_t          next_state;
    logic [BC_W-1:0] beat;
    logic [WW-1:0]   wr_word;
    logic [WW-1:0]   rd_word;
    logic [1:0]      wr_buf;
    logic [1:0]      rd_buf;
    logic [1:0]      ready_buf;
    logic            ready_pend;
    logic            rd_valid;
    logic            wr_hold;
    logic            rd_need;
    logic            last_grant;
    logic            frame_end;
    logic [PW-1:0]   rd_pend;

    logic wr_elig;
    logic rd_elig;
    logic accept;
    logic wr_accept;
    logic rd_accept;
    logic wr_frame_done;
    logic rd_frame_done;

    assign wr_elig   = (wf_usedw >= BL_LVL) && !wr_hold;
    assign rd_elig   = rd_need && rd_valid;
    assign accept    = ((state == WRITE) || (state == READ)) && !avs_waitrequest;
    assign wr_accept = accept && (state == WRITE);
    assign rd_accept = accept && (state == READ);

    // last_grant remembers which side owned the burst now sitting in DONE
    assign wr_frame_done = (state == DONE) && frame_end && last_grant;
    assign rd_frame_done = (state == DONE) && frame_end && !last_grant;

    assign wr_allow   = !wr_hold;
    assign avm_wrdata = wf_data;
    assign rf_data    = avs_rddata;
    assign rf_wrreq   = avs_rddata_vld && (rd_pend != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        avm_write  = 1'b0;
        avm_read   = 1'b0;
        avm_addr   = '0;
        wf_rdreq   = 1'b0;
        case (state)
            IDLE: begin
                if (wr_elig && (!rd_elig || !last_grant)) next_state = WRITE;
                else if (rd_elig)                         next_state = READ;
            end
            WRITE: begin
                avm_write = 1'b1;
                avm_addr  = {wr_buf, wr_word};
                wf_rdreq  = !avs_waitrequest;
                if (accept && (beat == LAST_BEAT)) next_state = DONE;
            end
            READ: begin
                avm_read = 1'b1;
                avm_addr = {rd_buf, rd_word};
                if (accept && (beat == LAST_BEAT)) next_state = DONE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat       <= '0;
            wr_word    <= '0;
            rd_word    <= '0;
            wr_buf     <= 2'd0;
            rd_buf     <= 2'd1;
            ready_buf  <= 2'd0;
            ready_pend <= 1'b0;
            rd_valid   <= 1'b0;
            wr_hold    <= 1'b0;
            rd_need    <= 1'b0;
            last_grant <= 1'b0;
            frame_end  <= 1'b0;
            rd_pend    <= '0;
        end else begin
            if (accept) begin
                if (beat == LAST_BEAT) beat <= '0;
                else                   beat <= beat + 1'b1;
            end

            if (state == IDLE) begin
                if (next_state == WRITE)     last_grant <= 1'b1;
                else if (next_state == READ) last_grant <= 1'b0;
            end

            if (state == DONE) frame_end <= 1'b0;

            if (wr_accept) begin
                if (wr_word == LAST_WORD) begin
                    wr_word   <= '0;
                    frame_end <= 1'b1;
                end else begin
                    wr_word <= wr_word + 1'b1;
                end
            end

            if (rd_accept) begin
                if (rd_word == LAST_WORD) begin
                    rd_word   <= '0;
                    frame_end <= 1'b1;
                end else begin
                    rd_word <= rd_word + 1'b1;
                end
            end

            // Triple buffering moves the writer to the one buffer neither displayed nor ready
            if (wr_frame_done) begin
                ready_buf  <= wr_buf;
                ready_pend <= 1'b1;
                rd_valid   <= 1'b1;
                if (NBUF == 3) wr_buf <= 2'd3 - rd_buf - wr_buf;
                else           wr_hold <= 1'b1;
            end

            if (rd_frame_done && ready_pend) begin
                rd_buf     <= ready_buf;
                ready_pend <= 1'b0;
                if (NBUF != 3) begin
                    wr_buf  <= rd_buf;
                    wr_hold <= 1'b0;
                end
            end

            if (rf_usedw <= RD_LT_LVL)     rd_need <= 1'b1;
            else if (rf_usedw > RD_UT_LVL) rd_need <= 1'b0;

            rd_pend <= rd_pend + {{(PW-1){1'b0}}, rd_accept} - {{(PW-1){1'b0}}, rf_wrreq};
        end
    end

`ifdef FB_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_wr_frames  <= '0;
            stat_rd_repeats <= '0;
        end else begin
            if (wr_frame_done && (stat_wr_frames != 16'hFFFF))
                stat_wr_frames <= stat_wr_frames + 1'b1;
            if (rd_frame_done && !ready_pend && (stat_rd_repeats != 16'hFFFF))
                stat_rd_repeats <= stat_rd_repeats + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sdram_fb_arbiter.sv
// Directed bench: ping-pong instance (a) and triple-buffered instance (b), BL=4, two bursts per frame.
// Stats checks are compiled in only when FB_STATS_EN is defined.
module tb_sdram_fb_arbiter;

    localparam int DW    = 16;
    localparam int AW    = 24;
    localparam int LVL_W = 11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic [LVL_W-1:0] wf_usedw_a, rf_usedw_a, wf_usedw_b, rf_usedw_b;
    logic [DW-1:0]    wf_data_a, rf_data_a, avm_wrdata_a, avs_rddata_a;
    logic [DW-1:0]    wf_data_b, rf_data_b, avm_wrdata_b, avs_rddata_b;
    logic             wf_rdreq_a, wr_allow_a, rf_wrreq_a, avm_write_a, avm_read_a;
    logic             wf_rdreq_b, wr_allow_b, rf_wrreq_b, avm_write_b, avm_read_b;
    logic             avs_rddata_vld_a, avs_waitrequest_a, avs_rddata_vld_b, avs_waitrequest_b;
    logic [AW-1:0]    avm_addr_a, avm_addr_b;
`ifdef FB_STATS_EN
    logic [15:0]      stat_wr_frames_a, stat_rd_repeats_a, stat_wr_frames_b, stat_rd_repeats_b;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    sdram_fb_arbiter #(.BL(4), .FRAME_BURSTS(2), .NBUF(2)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .wf_usedw(wf_usedw_a), .wf_data(wf_data_a), .wf_rdreq(wf_rdreq_a), .wr_allow(wr_allow_a),
        .rf_usedw(rf_usedw_a), .rf_wrreq(rf_wrreq_a), .rf_data(rf_data_a),
        .avm_write(avm_write_a), .avm_read(avm_read_a), .avm_addr(avm_addr_a), .avm_wrdata(avm_wrdata_a),
        .avs_rddata(avs_rddata_a), .avs_rddata_vld(avs_rddata_vld_a), .avs_waitrequest(avs_waitrequest_a)
`ifdef FB_STATS_EN
        , .stat_wr_frames(stat_wr_frames_a), .stat_rd_repeats(stat_rd_repeats_a)
`endif
    );

    sdram_fb_arbiter #(.BL(4), .FRAME_BURSTS(2), .NBUF(3)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .wf_usedw(wf_usedw_b), .wf_data(wf_data_b), .wf_rdreq(wf_rdreq_b), .wr_allow(wr_allow_b),
        .rf_usedw(rf_usedw_b), .rf_wrreq(rf_wrreq_b), .rf_data(rf_data_b),
        .avm_write(avm_write_b), .avm_read(avm_read_b), .avm_addr(avm_addr_b), .avm_wrdata(avm_wrdata_b),
        .avs_rddata(avs_rddata_b), .avs_rddata_vld(avs_rddata_vld_b), .avs_waitrequest(avs_waitrequest_b)
`ifdef FB_STATS_EN
        , .stat_wr_frames(stat_wr_frames_b), .stat_rd_repeats(stat_rd_repeats_b)
`endif
    );

    // Advance one clock, drive the per-cycle Avalon inputs of one instance, then let outputs settle
    task automatic applyStimulus(input bit to_b, input logic wait_req, input logic vld,
                                 input logic [DW-1:0] rddata);
        @(posedge clk);
        #1;
        if (to_b) begin
            avs_waitrequest_b = wait_req;
            avs_rddata_vld_b  = vld;
            avs_rddata_b      = rddata;
        end else begin
            avs_waitrequest_a = wait_req;
            avs_rddata_vld_a  = vld;
            avs_rddata_a      = rddata;
        end
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkCmd(input string tag, input bit to_b, input logic exp_w, input logic exp_r,
                            input logic [AW-1:0] exp_addr);
        logic          w;
        logic          r;
        logic [AW-1:0] a;
        w = to_b ? avm_write_b : avm_write_a;
        r = to_b ? avm_read_b  : avm_read_a;
        a = to_b ? avm_addr_b  : avm_addr_a;
        checkOutput({tag, " write"}, {31'b0, w}, {31'b0, exp_w});
        checkOutput({tag, " read"},  {31'b0, r}, {31'b0, exp_r});
        if (exp_w || exp_r) checkOutput({tag, " addr"}, {8'b0, a}, {8'b0, exp_addr});
    endtask

    initial begin
        wf_usedw_a = '0; wf_data_a = 16'hA5A5; rf_usedw_a = 11'd300;
        avs_rddata_a = '0; avs_rddata_vld_a = 1'b0; avs_waitrequest_a = 1'b0;
        wf_usedw_b = '0; wf_data_b = 16'h5A5A; rf_usedw_b = 11'd1025;
        avs_rddata_b = '0; avs_rddata_vld_b = 1'b0; avs_waitrequest_b = 1'b0;

        applyStimulus(0, 0, 0, '0);
        applyStimulus(0, 0, 0, '0);
        checkCmd("reset a", 0, 0, 0, '0);
        checkOutput("reset addr a", {8'b0, avm_addr_a}, 32'h0);
        checkOutput("reset wf_rdreq", {31'b0, wf_rdreq_a}, 32'd0);
        checkOutput("reset rf_wrreq", {31'b0, rf_wrreq_a}, 32'd0);
        checkOutput("reset wr_allow a", {31'b0, wr_allow_a}, 32'd1);
        checkOutput("reset addr b", {8'b0, avm_addr_b}, 32'h0);
        checkOutput("reset wr_allow b", {31'b0, wr_allow_b}, 32'd1);
        rst_n = 1'b1;

        applyStimulus(0, 0, 1, 16'h1111);
        checkOutput("stray vld no pend", {31'b0, rf_wrreq_a}, 32'd0);
        checkOutput("rd_need 300", {31'b0, dut_a.rd_need}, 32'd0);
        rf_usedw_a = 11'd250;
        applyStimulus(0, 0, 0, '0);
        checkOutput("rd_need 250", {31'b0, dut_a.rd_need}, 32'd1);
        rf_usedw_a = 11'd1000;
        applyStimulus(0, 0, 0, '0);
        checkOutput("rd_need 1000", {31'b0, dut_a.rd_need}, 32'd1);
        rf_usedw_a = 11'd1025;
        applyStimulus(0, 0, 0, '0);
        checkOutput("rd_need 1025", {31'b0, dut_a.rd_need}, 32'd0);
        rf_usedw_a = 11'd0;
        wf_usedw_a = 11'd8;

        // First write burst with three waitrequest cycles on beat 2
        applyStimulus(0, 0, 0, '0);
        checkCmd("a w0", 0, 1, 0, 24'h000000);
        checkOutput("a w0 rdreq", {31'b0, wf_rdreq_a}, 32'd1);
        checkOutput("a wrdata", {16'b0, avm_wrdata_a}, 32'h0000A5A5);
        applyStimulus(0, 0, 0, '0);
        checkCmd("a w1", 0, 1, 0, 24'h000001);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 0, '0);
            checkCmd("a stall", 0, 1, 0, 24'h000002);
            checkOutput("a stall rdreq", {31'b0, wf_rdreq_a}, 32'd0);
        end
        applyStimulus(0, 0, 0, '0);
        checkCmd("a w2", 0, 1, 0, 24'h000002);
        checkOutput("a w2 rdreq", {31'b0, wf_rdreq_a}, 32'd1);
        applyStimulus(0, 0, 0, '0);
        checkCmd("a w3", 0, 1, 0, 24'h000003);
        applyStimulus(0, 0, 0, '0);
        checkCmd("a done1", 0, 0, 0, '0);
        applyStimulus(0, 0, 0, '0);
        checkCmd("a idle1", 0, 0, 0, '0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, '0);
            checkCmd("a w burst2", 0, 1, 0, 24'(4 + i));
        end
        applyStimulus(0, 0, 0, '0);
        checkCmd("a done2", 0, 0, 0, '0);
        checkOutput("a allow in done", {31'b0, wr_allow_a}, 32'd1);
        applyStimulus(0, 0, 0, '0);
        checkOutput("a allow held", {31'b0, wr_allow_a}, 32'd0);
`ifdef FB_STATS_EN
        checkOutput("a stat_wr_frames", {16'b0, stat_wr_frames_a}, 32'd1);
`endif

        // Reader drains buffer 1 while the writer is held
        applyStimulus(0, 0, 0, '0);
        checkCmd("a r0", 0, 0, 1, 24'h400000);
        applyStimulus(0, 0, 1, 16'hBEEF);
        checkCmd("a r1", 0, 0, 1, 24'h400001);
        checkOutput("a rf_wrreq", {31'b0, rf_wrreq_a}, 32'd1);
        checkOutput("a rf_data", {16'b0, rf_data_a}, 32'h0000BEEF);
        for (int i = 2; i < 4; i++) begin
            applyStimulus(0, 0, 0, '0);
            checkCmd("a r burst1", 0, 0, 1, 24'h400000 + 24'(i));
        end
        applyStimulus(0, 0, 0, '0);
        checkCmd("a rdone1", 0, 0, 0, '0);
        applyStimulus(0, 0, 0, '0);
        checkOutput("a allow still held", {31'b0, wr_allow_a}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, '0);
            checkCmd("a r burst2", 0, 0, 1, 24'h400004 + 24'(i));
        end
        applyStimulus(0, 0, 0, '0);
        checkCmd("a rdone2", 0, 0, 0, '0);
        applyStimulus(0, 0, 0, '0);
        checkOutput("a allow after swap", {31'b0, wr_allow_a}, 32'd1);
`ifdef FB_STATS_EN
        checkOutput("a stat_rd_repeats", {16'b0, stat_rd_repeats_a}, 32'd0);
`endif

        // After the swap writer and reader alternate on opposite buffers
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, '0);
            checkCmd("a swap write", 0, 1, 0, 24'h400000 + 24'(i));
        end
        applyStimulus(0, 0, 0, '0);
        checkCmd("a alt done", 0, 0, 0, '0);
        applyStimulus(0, 0, 0, '0);
        checkCmd("a alt idle", 0, 0, 0, '0);
        applyStimulus(0, 0, 0, '0);
        checkCmd("a swap read0", 0, 0, 1, 24'h000000);
        applyStimulus(0, 0, 0, '0);
        checkCmd("a swap read1", 0, 0, 1, 24'h000001);
        rst_n = 1'b0;

        // One-cycle reset mid-read; returning data must be dropped
        applyStimulus(0, 0, 1, 16'hDEAD);
        checkCmd("a post reset", 0, 0, 0, '0);
        checkOutput("a post reset addr", {8'b0, avm_addr_a}, 32'h0);
        checkOutput("a drop vld0", {31'b0, rf_wrreq_a}, 32'd0);
        checkOutput("a post reset allow", {31'b0, wr_allow_a}, 32'd1);
        rst_n = 1'b1;
        applyStimulus(0, 0, 1, 16'hDEAD);
        checkOutput("a drop vld1", {31'b0, rf_wrreq_a}, 32'd0);
        checkCmd("a restart write", 0, 1, 0, 24'h000000);
        applyStimulus(0, 0, 1, 16'hDEAD);
        checkOutput("a drop vld2", {31'b0, rf_wrreq_a}, 32'd0);
        applyStimulus(0, 0, 1, 16'hDEAD);
        checkOutput("a drop vld3", {31'b0, rf_wrreq_a}, 32'd0);
        avs_rddata_vld_a = 1'b0;
        wf_usedw_a = '0;
        rf_usedw_a = 11'd1025;
        wf_usedw_b = 11'd8;
        rf_usedw_b = 11'd0;

        // Triple-buffered instance: one written frame, then the reader repeats it
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 0, '0);
            checkCmd("b w burst1", 1, 1, 0, 24'(i));
        end
        applyStimulus(1, 0, 0, '0);
        checkCmd("b done1", 1, 0, 0, '0);
        applyStimulus(1, 0, 0, '0);
        checkCmd("b idle1", 1, 0, 0, '0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 0, '0);
            checkCmd("b w burst2", 1, 1, 0, 24'(4 + i));
            if (i == 1) wf_usedw_b = '0;
        end
        applyStimulus(1, 0, 0, '0);
        checkCmd("b done2", 1, 0, 0, '0);
        applyStimulus(1, 0, 0, '0);
        checkOutput("b allow never held", {31'b0, wr_allow_b}, 32'd1);
        for (int f = 0; f < 2; f++) begin
            for (int h = 0; h < 2; h++) begin
                for (int i = 0; i < 4; i++) begin
                    applyStimulus(1, 0, 0, '0);
                    checkCmd("b read", 1, 0, 1, ((f == 0) ? 24'h400000 : 24'h000000) + 24'(4 * h + i));
                end
                applyStimulus(1, 0, 0, '0);
                checkCmd("b rdone", 1, 0, 0, '0);
                applyStimulus(1, 0, 0, '0);
                checkCmd("b ridle", 1, 0, 0, '0);
            end
`ifdef FB_STATS_EN
            checkOutput("b stat_rd_repeats", {16'b0, stat_rd_repeats_b}, (f == 0) ? 32'd0 : 32'd1);
            checkOutput("b stat_wr_frames", {16'b0, stat_wr_frames_b}, 32'd1);
`endif
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 0, '0);
            checkCmd("b reread", 1, 0, 1, 24'(i));
            if (i == 0) wf_usedw_b = 11'd8;
        end
        applyStimulus(1, 0, 0, '0);
        checkCmd("b rr done", 1, 0, 0, '0);
        applyStimulus(1, 0, 0, '0);
        checkCmd("b rr idle", 1, 0, 0, '0);
        applyStimulus(1, 0, 0, '0);
        checkCmd("b third buffer write", 1, 1, 0, 24'h800000);
        checkOutput("b allow third", {31'b0, wr_allow_b}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
